mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of write-back.
- Latches the 103-bit execute-to-memory bus and waits for the data SRAM read response on loads; a response may take one or more cycles.
- Holds the read data if write-back stalls, then selects the final result (load data or ALU result).
- Drives the write-back bus, a hazard/forwarding bus for the decode stage, and a load-stall cycle counter.

Parameters:
- EM_BUS_W, 103, width of the execute-to-memory bus: {alu_result[31:0], res_from_mem, gr_we, dest[4:0], pc[31:0], inst[31:0]}, MSB first.
- MW_BUS_W, 70, width of the memory-to-write-back bus: {final_result[31:0], gr_we, dest[4:0], pc[31:0]}, MSB first.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- MEM_allow_in  out  1  stage can accept a new instruction this cycle.
- EXE_to_MEM_valid  in  1  execute stage presents a valid instruction.
- EXE_to_MEM_bus  in  EM_BUS_W  execute payload.
- MEM_to_WB_valid  out  1  valid instruction offered to write-back.
- WB_allow_in  in  1  write-back accepts this cycle.
- MEM_to_WB_bus  out  MW_BUS_W  write-back payload.
- data_sram_rvalid  in  1  read data valid this cycle.
- data_sram_rdata  in  32  read data.
- MEM_wr_bus  out  39  {we_valid, fwd_ok, dest[4:0], final_result[31:0]}, for hazard detection and forwarding in decode.
- load_stall_cnt  out  32  count of cycles a load waited on memory.

Behaviour:
- Reset (resetn=0, asynchronous): MEM_valid=0, latched bus=0, rdata_buf=0, rdata_buf_valid=0, load_stall_cnt=0.
  - Resulting outputs: MEM_to_WB_valid=0, MEM_allow_in=1, MEM_wr_bus=0.
  - Reset mid-load discards the instruction and any buffered data.
- MEM_valid update: when MEM_allow_in=1, MEM_valid <= EXE_to_MEM_valid.
- Bus latch: bus register loads EXE_to_MEM_bus only when EXE_to_MEM_valid & MEM_allow_in; otherwise it holds.
- ready_go = ~res_from_mem | data_sram_rvalid | rdata_buf_valid.
- MEM_allow_in = ~MEM_valid | (ready_go & WB_allow_in).
- MEM_to_WB_valid = MEM_valid & ready_go.
- fire = MEM_to_WB_valid & WB_allow_in (instruction leaves the stage this cycle).
- Load data select: load_data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- final_result = res_from_mem ? load_data : alu_result. Full 32-bit word; no byte or halfword extraction.
- Read-data buffer:
  - On MEM_valid & res_from_mem & data_sram_rvalid & ~rdata_buf_valid & ~fire: rdata_buf <= data_sram_rdata and rdata_buf_valid <= 1.
  - On fire: rdata_buf_valid <= 0.
  - data_sram_rvalid is ignored when MEM_valid=0, when res_from_mem=0, or when rdata_buf_valid=1. Such pulses are spurious or duplicate and must not change any state.
  - If a response and fire occur in the same cycle, data passes straight through and the buffer stays empty.
- Latency:
  - Non-load: 1 cycle in the stage when WB_allow_in=1.
  - Load: 1 + N cycles, where N is the number of cycles before the first rvalid.
  - Back-to-back instructions are accepted with no bubble when ready_go=1 and WB_allow_in=1.
- MEM_to_WB_bus = {final_result, gr_we, dest, pc}. inst is dropped.
- MEM_wr_bus:
  - we_valid = gr_we & MEM_valid.
  - fwd_ok = ready_go.
  - dest and final_result are passed through.
  - Decode must stall, not forward, when we_valid=1 and fwd_ok=0.
- load_stall_cnt: +1 each cycle MEM_valid & res_from_mem & ~ready_go. Saturates at 0xFFFF_FFFF and does not wrap.
- No combinational path from EXE_to_MEM_bus to any output.

Test Plan:
1. Three back-to-back ALU ops (alu_result 0x11, 0x22, 0x33; gr_we=1; dest 1, 2, 3) with WB_allow_in=1 -> MEM_to_WB_valid=1 for 3 consecutive cycles, results 0x11/0x22/0x33 in order, load_stall_cnt=0.
2. Load (res_from_mem=1, dest=5), rvalid 3 cycles after entry with rdata=0xDEADBEEF -> MEM_allow_in=0 and fwd_ok=0 for 3 cycles; load_stall_cnt=3; then final_result=0xDEADBEEF, dest=5.
3. Load with rvalid the same cycle as entry, rdata=0xCAFE0001, while WB_allow_in=0 for 2 cycles -> rdata_buf_valid=1; final_result stays 0xCAFE0001 while rdata_sram changes to 0x0; retires the cycle WB_allow_in=1; rdata_buf_valid=0 afterwards.
4. Spurious rvalid (rdata 0x1234) during a non-load, and while MEM_valid=0 -> no state change; results unaffected; rdata_buf_valid stays 0.
5. Assert resetn=0 mid-load, between clock edges -> MEM_valid=0 and MEM_allow_in=1 immediately; the late rvalid after reset release is ignored; counter=0.
6. Force load_stall_cnt to 0xFFFF_FFFE, stall a load 3 cycles -> counter reads 0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and data bundle around the memory-access stage: execute-side input,
// write-back-side output, data SRAM read response and the decode-facing hazard bus.
interface mem_stage_if #(
    parameter int EM_BUS_W = 103,
    parameter int MW_BUS_W = 70
);
    logic                MEM_allow_in;
    logic                EXE_to_MEM_valid;
    logic [EM_BUS_W-1:0] EXE_to_MEM_bus;
    logic                MEM_to_WB_valid;
    logic                WB_allow_in;
    logic [MW_BUS_W-1:0] MEM_to_WB_bus;
    logic                data_sram_rvalid;
    logic [31:0]         data_sram_rdata;
    logic [38:0]         MEM_wr_bus;
    logic [31:0]         load_stall_cnt;

    // The stage itself.
    modport slave (
        output MEM_allow_in,
        input  EXE_to_MEM_valid,
        input  EXE_to_MEM_bus,
        output MEM_to_WB_valid,
        input  WB_allow_in,
        output MEM_to_WB_bus,
        input  data_sram_rvalid,
        input  data_sram_rdata,
        output MEM_wr_bus,
        output load_stall_cnt
    );

    // The surrounding pipeline and memory.
    modport master (
        input  MEM_allow_in,
        output EXE_to_MEM_valid,
        output EXE_to_MEM_bus,
        input  MEM_to_WB_valid,
        output WB_allow_in,
        input  MEM_to_WB_bus,
        output data_sram_rvalid,
        output data_sram_rdata,
        input  MEM_wr_bus,
        input  load_stall_cnt
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, waits for / buffers the
// data SRAM read response on loads, and hands the final result to write-back.
module mem_stage #(
    parameter int EM_BUS_W = 103,
    parameter int MW_BUS_W = 70
) (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave mif
);
    logic                mem_valid;
    logic [EM_BUS_W-1:32] em_q;
    logic [31:0]         rdata_buf;
    logic                rdata_buf_valid;
    logic [31:0]         stall_cnt;

    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        ready_go;
    logic        allow_in;
    logic        to_wb_valid;
    logic        fire;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic [MW_BUS_W-1:0] mw_bus;

    // The instruction word is not needed past execute, so it is never latched.
    logic unused_inst;
    assign unused_inst = ^mif.EXE_to_MEM_bus[31:0];

    assign {alu_result, res_from_mem, gr_we, dest, pc} = em_q;

    assign ready_go     = ~res_from_mem | mif.data_sram_rvalid | rdata_buf_valid;
    assign allow_in     = ~mem_valid | (ready_go & mif.WB_allow_in);
    assign to_wb_valid  = mem_valid & ready_go;
    assign fire         = to_wb_valid & mif.WB_allow_in;
    assign load_data    = rdata_buf_valid ? rdata_buf : mif.data_sram_rdata;
    assign final_result = res_from_mem ? load_data : alu_result;
    assign mw_bus       = {final_result, gr_we, dest, pc};

    // NOTE: all state below is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (allow_in) begin
            mem_valid <= mif.EXE_to_MEM_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            em_q <= '0;
        end else if (mif.EXE_to_MEM_valid && allow_in) begin
            em_q <= mif.EXE_to_MEM_bus[EM_BUS_W-1:32];
        end
    end

    // Capture the response only when it cannot leave this cycle; duplicates and
    // responses with no load in flight leave the buffer untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf       <= 32'd0;
            rdata_buf_valid <= 1'b0;
        end else if (mem_valid && res_from_mem && mif.data_sram_rvalid &&
                     !rdata_buf_valid && !fire) begin
            rdata_buf       <= mif.data_sram_rdata;
            rdata_buf_valid <= 1'b1;
        end else if (fire) begin
            rdata_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= 32'd0;
        end else if (mem_valid && res_from_mem && !ready_go && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign mif.MEM_allow_in    = allow_in;
    assign mif.MEM_to_WB_valid = to_wb_valid;
    assign mif.MEM_to_WB_bus   = mw_bus;
    assign mif.load_stall_cnt  = stall_cnt;
    // fwd_ok is qualified by mem_valid so the hazard bus reads all-zero while idle.
    assign mif.MEM_wr_bus      = {gr_we & mem_valid, ready_go & mem_valid, dest, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: retiring results are compared against a scoreboard
// queue filled when each instruction is driven; side outputs are checked inline.
module tb_mem_stage;
    logic clk;
    logic resetn;

    mem_stage_if #(.EM_BUS_W(103), .MW_BUS_W(70)) mif ();

    mem_stage #(.EM_BUS_W(103), .MW_BUS_W(70)) dut (
        .clk    (clk),
        .resetn (resetn),
        .mif    (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [69:0] sb[$];

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [102:0] em(input logic [31:0] alu, input logic rfm,
                                        input logic we, input logic [4:0] d,
                                        input logic [31:0] pc);
        return {alu, rfm, we, d, pc, pc ^ 32'h0013_0A5A};
    endfunction

    function automatic logic [69:0] mw(input logic [31:0] res, input logic we,
                                       input logic [4:0] d, input logic [31:0] pc);
        return {res, we, d, pc};
    endfunction

    task automatic drive(input logic [31:0] alu, input logic rfm, input logic [4:0] d,
                         input logic [31:0] pc, input logic [31:0] exp_res);
        mif.EXE_to_MEM_valid = 1'b1;
        mif.EXE_to_MEM_bus   = em(alu, rfm, 1'b1, d, pc);
        sb.push_back(mw(exp_res, 1'b1, d, pc));
    endtask

    // Retire monitor: every accepted write-back transfer must match the queue head.
    always @(negedge clk) begin
        if (resetn && mif.MEM_to_WB_valid && mif.WB_allow_in) begin
            n_cmp++;
            assert (sb.size() > 0)
            else begin
                n_err++;
                $error("FAIL wb_unexpected: observed retire %h expected none", mif.MEM_to_WB_bus);
            end
            if (sb.size() > 0) check("wb_bus", mif.MEM_to_WB_bus, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn               = 1'b0;
        mif.EXE_to_MEM_valid = 1'b0;
        mif.EXE_to_MEM_bus   = '0;
        mif.WB_allow_in      = 1'b1;
        mif.data_sram_rvalid = 1'b0;
        mif.data_sram_rdata  = 32'd0;
        #2;
        check("rst_wb_valid", 70'(mif.MEM_to_WB_valid), 70'(1'b0));
        check("rst_allow_in", 70'(mif.MEM_allow_in), 70'(1'b1));
        check("rst_wr_bus",   70'(mif.MEM_wr_bus), 70'd0);
        check("rst_cnt",      70'(mif.load_stall_cnt), 70'd0);
        tick();
        tick();
        resetn = 1'b1;

        // 1: three back-to-back ALU ops
        tick();
        drive(32'h11, 1'b0, 5'd1, 32'h100, 32'h11);
        tick();
        drive(32'h22, 1'b0, 5'd2, 32'h104, 32'h22);
        @(negedge clk);
        check("b2b_valid0", 70'(mif.MEM_to_WB_valid), 70'(1'b1));
        check("b2b_allow0", 70'(mif.MEM_allow_in), 70'(1'b1));
        tick();
        drive(32'h33, 1'b0, 5'd3, 32'h108, 32'h33);
        @(negedge clk);
        check("b2b_valid1", 70'(mif.MEM_to_WB_valid), 70'(1'b1));
        tick();
        mif.EXE_to_MEM_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid2", 70'(mif.MEM_to_WB_valid), 70'(1'b1));
        tick();
        @(negedge clk);
        check("b2b_idle", 70'(mif.MEM_to_WB_valid), 70'(1'b0));
        check("b2b_cnt",  70'(mif.load_stall_cnt), 70'd0);

        // 2: load, response three cycles after entry
        tick();
        drive(32'h55, 1'b1, 5'd5, 32'h200, 32'hDEAD_BEEF);
        tick();
        mif.EXE_to_MEM_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_allow",   70'(mif.MEM_allow_in), 70'(1'b0));
            check("ld_fwd_ok",  70'(mif.MEM_wr_bus[37]), 70'(1'b0));
            check("ld_we_valid", 70'(mif.MEM_wr_bus[38]), 70'(1'b1));
            tick();
        end
        mif.data_sram_rvalid = 1'b1;
        mif.data_sram_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("ld_wb_valid", 70'(mif.MEM_to_WB_valid), 70'(1'b1));
        check("ld_wr_bus",   70'(mif.MEM_wr_bus), 70'({1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF}));
        tick();
        mif.data_sram_rvalid = 1'b0;
        mif.data_sram_rdata  = 32'd0;
        check("ld_cnt", 70'(mif.load_stall_cnt), 70'd3);

        // 3: immediate response while write-back stalls for two cycles
        drive(32'h66, 1'b1, 5'd6, 32'h300, 32'hCAFE_0001);
        tick();
        mif.EXE_to_MEM_valid = 1'b0;
        mif.data_sram_rvalid = 1'b1;
        mif.data_sram_rdata  = 32'hCAFE_0001;
        mif.WB_allow_in      = 1'b0;
        @(negedge clk);
        check("buf_wb_valid", 70'(mif.MEM_to_WB_valid), 70'(1'b1));
        tick();
        mif.data_sram_rvalid = 1'b0;
        mif.data_sram_rdata  = 32'd0;
        @(negedge clk);
        check("buf_valid",  70'(dut.rdata_buf_valid), 70'(1'b1));
        check("buf_result", 70'(mif.MEM_to_WB_bus[69:38]), 70'(32'hCAFE_0001));
        check("buf_allow",  70'(mif.MEM_allow_in), 70'(1'b0));
        tick();
        mif.WB_allow_in = 1'b1;
        tick();
        @(negedge clk);
        check("buf_cleared",  70'(dut.rdata_buf_valid), 70'(1'b0));
        check("buf_wb_idle",  70'(mif.MEM_to_WB_valid), 70'(1'b0));
        check("buf_cnt",      70'(mif.load_stall_cnt), 70'd3);

        // 4: spurious responses while idle and during a stalled non-load
        tick();
        mif.data_sram_rvalid = 1'b1;
        mif.data_sram_rdata  = 32'h1234;
        tick();
        check("spur_idle_buf", 70'(dut.rdata_buf_valid), 70'(1'b0));
        check("spur_idle_cnt", 70'(mif.load_stall_cnt), 70'd3);
        check("spur_idle_wb",  70'(mif.MEM_to_WB_valid), 70'(1'b0));
        drive(32'h44, 1'b0, 5'd7, 32'h400, 32'h44);
        tick();
        mif.EXE_to_MEM_valid = 1'b0;
        mif.WB_allow_in      = 1'b0;
        @(negedge clk);
        check("spur_alu_res", 70'(mif.MEM_wr_bus[31:0]), 70'(32'h44));
        tick();
        check("spur_alu_buf", 70'(dut.rdata_buf_valid), 70'(1'b0));
        mif.WB_allow_in      = 1'b1;
        mif.data_sram_rvalid = 1'b0;
        mif.data_sram_rdata  = 32'd0;
        tick();
        @(negedge clk);
        check("spur_done", 70'(mif.MEM_to_WB_valid), 70'(1'b0));

        // 5: reset in the middle of a load, then a late response
        tick();
        mif.EXE_to_MEM_valid = 1'b1;
        mif.EXE_to_MEM_bus   = em(32'h77, 1'b1, 1'b1, 5'd8, 32'h500);
        tick();
        mif.EXE_to_MEM_valid = 1'b0;
        @(negedge clk);
        check("mid_allow_pre", 70'(mif.MEM_allow_in), 70'(1'b0));
        #2;
        resetn = 1'b0;
        #1;
        check("mid_allow",  70'(mif.MEM_allow_in), 70'(1'b1));
        check("mid_wb",     70'(mif.MEM_to_WB_valid), 70'(1'b0));
        check("mid_wr_bus", 70'(mif.MEM_wr_bus), 70'd0);
        check("mid_cnt",    70'(mif.load_stall_cnt), 70'd0);
        tick();
        tick();
        resetn               = 1'b1;
        mif.data_sram_rvalid = 1'b1;
        mif.data_sram_rdata  = 32'hBAD0_BAD0;
        tick();
        mif.data_sram_rvalid = 1'b0;
        mif.data_sram_rdata  = 32'd0;
        check("late_buf",   70'(dut.rdata_buf_valid), 70'(1'b0));
        check("late_cnt",   70'(mif.load_stall_cnt), 70'd0);
        check("late_wb",    70'(mif.MEM_to_WB_valid), 70'(1'b0));
        check("late_allow", 70'(mif.MEM_allow_in), 70'(1'b1));

        // 6: stall counter saturation
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        check("sat_preset", 70'(mif.load_stall_cnt), 70'(32'hFFFF_FFFE));
        drive(32'h88, 1'b1, 5'd9, 32'h600, 32'h600D_600D);
        tick();
        mif.EXE_to_MEM_valid = 1'b0;
        @(negedge clk);
        check("sat_c0", 70'(mif.load_stall_cnt), 70'(32'hFFFF_FFFE));
        tick();
        @(negedge clk);
        check("sat_c1", 70'(mif.load_stall_cnt), 70'(32'hFFFF_FFFF));
        tick();
        tick();
        mif.data_sram_rvalid = 1'b1;
        mif.data_sram_rdata  = 32'h600D_600D;
        @(negedge clk);
        check("sat_c3", 70'(mif.load_stall_cnt), 70'(32'hFFFF_FFFF));
        tick();
        mif.data_sram_rvalid = 1'b0;
        mif.data_sram_rdata  = 32'd0;
        check("sat_hold", 70'(mif.load_stall_cnt), 70'(32'hFFFF_FFFF));
        tick();
        check("sb_empty", 70'(sb.size()), 70'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
